// File: rtl/weights_packer.sv
// Packs 8-bit weight bytes into BYTES_PER_WORD-byte words; 1-cycle latency, one-deep output register.
// Optional WEIGHTS_PACKER_PARITY_EN adds per-byte even parity (out_parity) registered with out_data.
module weights_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_W          = $clog2(BYTES_PER_WORD)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            fill_level,
  output logic [15:0]                 words_out
`ifdef WEIGHTS_PACKER_PARITY_EN
  ,
  output logic [BYTES_PER_WORD-1:0]   out_parity
`endif
);

  localparam int N = BYTES_PER_WORD;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0]     cnt;
  logic [8*(N-1)-1:0]   acc;
  logic [8*N-1:0]       new_word;
  logic                 last;
  logic                 in_fire;
  logic                 out_fire;
  logic                 complete;

  assign last       = (cnt == LAST);
  // Only the final byte of a word waits on the output register.
  assign in_ready   = !flush && (!last || !out_valid || out_ready);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign complete   = in_fire && last;
  assign new_word   = {in_data, acc};
  assign fill_level = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      words_out <= '0;
    end else begin
      if (flush) begin
        cnt <= '0;
      end else if (in_fire) begin
        if (last) begin
          out_data <= new_word;
          cnt      <= '0;
        end else begin
          acc[{cnt, 3'b000} +: 8] <= in_data;
          cnt                     <= cnt + CNT_W'(1);
        end
      end
      if (complete)
        out_valid <= 1'b1;
      else if (out_fire)
        out_valid <= 1'b0;
      if (out_fire)
        words_out <= words_out + 16'd1;
    end
  end

`ifdef WEIGHTS_PACKER_PARITY_EN
  logic [N-1:0] par_next;

  always_comb begin
    par_next = '0;
    for (int i = 0; i < N; i++)
      par_next[i] = ^new_word[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_parity <= '0;
    else if (complete)
      out_parity <= par_next;
  end
`endif

endmodule

// File: tb/tb_weights_packer.sv
// Bench for weights_packer: queue-based word model checked every cycle plus directed literal checks.
module tb_weights_packer;

  localparam int N = 4;
  localparam int CW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [8*N-1:0]   out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    fill_level;
  logic [15:0]      words_out;
`ifdef WEIGHTS_PACKER_PARITY_EN
  logic [N-1:0]     out_parity;
`endif

  weights_packer #(.BYTES_PER_WORD(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level),
    .words_out  (words_out)
`ifdef WEIGHTS_PACKER_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes of the word being assembled, the pending output word, handed-off words.
  logic [7:0]     part[$];
  logic [8*N-1:0] got[$];
  logic [8*N-1:0] m_word = '0;
  logic           m_vld = 1'b0;
  logic [15:0]    m_words = '0;
  logic           m_rdy, m_ofire, m_done;

  function automatic logic exp_ready();
    return !flush && (part.size() != N - 1 || !m_vld || out_ready);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      part.delete();
      m_vld   = 1'b0;
      m_word  = '0;
      m_words = '0;
    end else begin
      m_rdy   = exp_ready();
      m_ofire = m_vld && out_ready;
      m_done  = 1'b0;
      if (m_ofire) begin
        m_words = m_words + 16'd1;
        got.push_back(m_word);
      end
      if (in_valid && m_rdy) begin
        part.push_back(in_data);
        if (part.size() == N) begin
          for (int i = 0; i < N; i++) m_word[8*i +: 8] = part[i];
          part.delete();
          m_done = 1'b1;
        end
      end
      if (flush) part.delete();
      if (m_done) m_vld = 1'b1;
      else if (m_ofire) m_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(out_valid), 64'(m_vld));
      if (m_vld) chk("out_data", 64'(out_data), 64'(m_word));
      chk("fill_level", 64'(fill_level), 64'(part.size()));
      chk("words_out", 64'(words_out), 64'(m_words));
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
`ifdef WEIGHTS_PACKER_PARITY_EN
      if (m_vld) begin
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = ^m_word[8*i +: 8];
        chk("out_parity", 64'(out_parity), 64'(p));
      end
`endif
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_words", 64'(words_out), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single word at full rate.
    cyc(1, 8'h11, 1, 0); cyc(1, 8'h22, 1, 0); cyc(1, 8'h33, 1, 0); cyc(1, 8'h44, 1, 0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'h44332211);
    cyc(0, 8'h00, 1, 0);
    chk("t1_valid_drop", 64'(out_valid), 64'd0);
    chk("t1_words", 64'(words_out), 64'd1);

    // Output stalled: second word's last byte must wait.
    got.delete();
    for (int i = 1; i <= 7; i++) cyc(1, 8'(i), 0, 0);
    chk("t2_fill3", 64'(fill_level), 64'd3);
    chk("t2_hold_data", 64'(out_data), 64'h04030201);
    chk("t2_stall_rdy", 64'(in_ready), 64'd0);
    cyc(1, 8'h08, 0, 0);
    cyc(1, 8'h08, 0, 0);
    chk("t2_hold_data2", 64'(out_data), 64'h04030201);
    chk("t2_hold_valid", 64'(out_valid), 64'd1);
    chk("t2_stall_rdy2", 64'(in_ready), 64'd0);
    in_valid = 1; in_data = 8'h08; out_ready = 1; flush = 0;
    #1 chk("t2_release_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("t2_word2", 64'(out_data), 64'h08070605);
    chk("t2_valid2", 64'(out_valid), 64'd1);
    chk("t2_words", 64'(words_out), 64'd2);
    cyc(0, 8'h00, 1, 0);
    chk("t2_words_drain", 64'(words_out), 64'd3);
    chk("t2_got_n", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("t2_got0", 64'(got[0]), 64'h04030201);
      chk("t2_got1", 64'(got[1]), 64'h08070605);
    end

    // Continuous stream, no stalls.
    got.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_data = 8'(i); out_ready = 1; flush = 0;
      #1 chk("t3_rdy", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    cyc(0, 8'h00, 1, 0);
    chk("t3_got_n", 64'(got.size()), 64'd4);
    if (got.size() == 4) begin
      chk("t3_w0", 64'(got[0]), 64'h03020100);
      chk("t3_w1", 64'(got[1]), 64'h07060504);
      chk("t3_w2", 64'(got[2]), 64'h0B0A0908);
      chk("t3_w3", 64'(got[3]), 64'h0F0E0D0C);
    end
    chk("t3_words", 64'(words_out), 64'd7);

    // Flush discards partial word and blocks the coincident byte.
    got.delete();
    cyc(1, 8'hAA, 1, 0); cyc(1, 8'hBB, 1, 0);
    in_valid = 1; in_data = 8'hCC; out_ready = 1; flush = 1;
    #1 chk("t4_flush_rdy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("t4_fill0", 64'(fill_level), 64'd0);
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 1, 0);
    cyc(0, 8'h00, 1, 0);
    chk("t4_got_n", 64'(got.size()), 64'd1);
    if (got.size() == 1) chk("t4_w0", 64'(got[0]), 64'h04030201);

    // Asynchronous reset mid-cycle.
    for (int i = 1; i <= 6; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    chk("t5_pre_fill", 64'(fill_level), 64'd2);
    chk("t5_pre_valid", 64'(out_valid), 64'd1);
    cyc(0, 8'h00, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid0", 64'(out_valid), 64'd0);
    chk("t5_fill0", 64'(fill_level), 64'd0);
    chk("t5_words0", 64'(words_out), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    in_valid = 0; out_ready = 1;
    #1 chk("t5_rdy_after", 64'(in_ready), 64'd1);

`ifdef WEIGHTS_PACKER_PARITY_EN
    @(posedge clk); #1;
    cyc(1, 8'h01, 1, 0); cyc(1, 8'h03, 1, 0); cyc(1, 8'h07, 1, 0); cyc(1, 8'hFF, 1, 0);
    chk("t6_parity", 64'(out_parity), 64'b0101);
    chk("t6_data", 64'(out_data), 64'hFF070301);
`endif

    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
